// File: rtl/frame_cmd_scheduler.sv
// Queues host command writes and releases them onto the shared sprite
// command bus only during vertical blanking, one frame group per vblank.
module frame_cmd_scheduler #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned V_ACTIVE   = 480,
  parameter logic [5:0]  BARRIER_ID = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avl_chipselect,
  input  logic        avl_write,
  input  logic [31:0] avl_writedata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] writedata,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        overflow,
  output logic [7:0]  frame_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          wr_req;
  logic          push;
  logic          pop;
  logic          frame_inc;
  logic          vblank;
  logic          vblank_start;
  logic [31:0]   head;
  logic          head_is_barrier;
  logic [31:0]   writedata_nxt;

  // Status flags and blanking decode, all from the pre-cycle count
  assign fifo_full       = (count == CW'(DEPTH));
  assign fifo_empty      = (count == '0);
  assign vblank          = (vcount >= 10'(V_ACTIVE));
  assign vblank_start    = (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);
  assign wr_req          = avl_chipselect && avl_write;
  assign push            = wr_req && !fifo_full;
  assign head            = mem[rd_ptr];
  assign head_is_barrier = (head[31:26] == BARRIER_ID);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_ACTIVE;
    else       state <= state_nxt;
  end

  // Next state, pop decision and next bus word; leaving vblank beats a pop
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    frame_inc     = 1'b0;
    writedata_nxt = 32'h0;
    case (state)
      ST_ACTIVE: begin
        if (vblank_start) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!vblank) begin
          state_nxt = ST_ACTIVE;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (head_is_barrier) begin
            frame_inc = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            writedata_nxt = head;
          end
        end
      end
      ST_DONE: begin
        if (!vblank) state_nxt = ST_ACTIVE;
      end
      default: state_nxt = ST_ACTIVE;
    endcase
  end

  // FIFO storage; no reset needed since pointers/count gate validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avl_writedata;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered bus word, sticky overflow and frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      writedata   <= 32'h0;
      overflow    <= 1'b0;
      frame_count <= 8'h0;
    end else begin
      writedata <= writedata_nxt;
      if (wr_req && fifo_full) overflow <= 1'b1;
      if (frame_inc) frame_count <= frame_count + 8'd1;
    end
  end

endmodule
